// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit ripple-carry
// adder over WIDTH/4 clock cycles, LSB nibble first.
// The carry is registered between nibbles, and the result is assembled
// in a shift register.
// Handshake: start is accepted only in IDLE. busy covers CALC and DONE.
// done pulses for one cycle when sum/cout are updated.
// Optional macro NIBBLE_SERIAL_ADDER_SUB_EN adds the sub input and the
// ovf output, for subtraction and signed-overflow reporting.
`timescale 1ns/1ps

// Team 4-bit ripple-carry adder: four chained full adders.
module RCA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[4];
endmodule

// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder #(
  parameter  int WIDTH   = 16,
  localparam int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;        // operand A, shifted right one nibble per CALC edge
  logic [WIDTH-1:0] r_b;        // operand B (inverted for subtract), shifted likewise
  logic [WIDTH-1:0] r_res;      // result nibbles enter at the top, shift down
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic [3:0]       w_rca_sum;
  logic             w_rca_cout;
  logic [WIDTH+3:0] w_res_cat;
  logic [WIDTH-1:0] w_res_next;
  logic             w_accept;
  logic             w_calc;
  logic             w_last;
  logic             w_sub;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  // The low nibble of each operand shift register is always the one being processed.
  RCA_4bit u_rca (
    .a    (r_a[3:0]),
    .b    (r_b[3:0]),
    .cin  (r_carry),
    .sum  (w_rca_sum),
    .cout (w_rca_cout)
  );

  assign w_res_cat  = {w_rca_sum, r_res};
  assign w_res_next = w_res_cat[WIDTH+3:4];
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_calc     = (r_state == S_CALC);
  assign w_last     = w_calc && (r_idx == LAST_IDX);

  // State register; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: IDLE -> CALC on start, CALC -> DONE after the last nibble, DONE -> IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)            w_state_next = S_CALC;
      S_CALC:  if (r_idx == LAST_IDX) w_state_next = S_DONE;
      S_DONE:                        w_state_next = S_IDLE;
      default:                       w_state_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, step one nibble per CALC edge, publish on the last one.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) so every register samples pre-edge values; blocking here would chain them.
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_state_next != S_IDLE);
      r_done <= (w_state_next == S_DONE);
      if (w_accept) begin
        r_a     <= a;
        r_b     <= w_sub ? ~b : b;
        r_carry <= w_sub ? 1'b1 : cin;
        r_idx   <= '0;
      end else if (w_calc) begin
        r_a     <= r_a >> 4;
        r_b     <= r_b >> 4;
        r_res   <= w_res_next;
        r_carry <= w_rca_cout;
        r_idx   <= r_idx + 1'b1;
        if (w_last) begin
          r_sum  <= w_res_next;
          r_cout <= w_rca_cout;
        end
      end
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic r_ovf;

  // On the last nibble the operand MSBs are bit 3 of the nibble.
  // Overflow means both operands agree in sign and the result sign differs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= (r_a[3] == r_b[3]) && (w_rca_sum[3] != r_a[3]);
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (default build, add only).
// A 16-bit DUT is checked by a queue scoreboard fed from a cycle-level
// reference model.
// A 4-bit DUT is checked directly around each operation.
`timescale 1ns/1ps

module tb_nibble_serial_adder;
  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic         start4 = 1'b0;
  logic [3:0]   a4 = '0;
  logic [3:0]   b4 = '0;
  logic         cin4 = 1'b0;
  logic         busy4, done4, cout4;
  logic [3:0]   sum4;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           done_edge;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           edge_no = 0;
  int           next_free = 0;
  int           acc_edge = -100;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // Reference model.
  // An accept happens when start is high and the adder is free, and completion
  // is due N edges later.
  // The adder becomes free N+2 edges after an accept.
  always @(posedge clk) begin
    logic [W:0] total;
    edge_no++;
    if (rst) begin
      sb_q.delete();
      next_free = edge_no + 1;
      acc_edge  = -100;
      m_sum     = '0;
      m_cout    = 1'b0;
    end else begin
      if (sb_q.size() > 0 && sb_q[0].done_edge == edge_no) begin
        m_sum  = sb_q[0].sum;
        m_cout = sb_q[0].cout;
      end
      if (start && edge_no >= next_free) begin
        total = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
        sb_q.push_back('{sum: total[W-1:0], cout: total[W], done_edge: edge_no + N});
        acc_edge  = edge_no;
        next_free = edge_no + N + 2;
      end
    end
    m_busy = (edge_no >= acc_edge) && (edge_no <= acc_edge + N);
  end

  // Monitor: pops the scoreboard on every done pulse.
  // Each cycle it also checks busy and the held result.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("done_edge", edge_no, e.done_edge);
        check("done_sum", sum, e.sum);
        check("done_cout", cout, e.cout);
      end
    end else if (sb_q.size() > 0 && sb_q[0].done_edge <= edge_no) begin
      check("missing_done", 0, 1);
      void'(sb_q.pop_front());
    end
    check("busy", busy, m_busy);
    check("held_sum", sum, m_sum);
    check("held_cout", cout, m_cout);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on the 16-bit DUT.
  // Operands are scrambled after accept, and the task returns once the DUT is idle again.
  task automatic op16(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    a = xa; b = xb; cin = xc; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    repeat (N + 1) tick();
  endtask

  // One operation on the 4-bit DUT: a single CALC cycle, then DONE.
  task automatic op4(input logic [3:0] xa, input logic [3:0] xb, input logic xc);
    logic [4:0] t;
    t  = {1'b0, xa} + {1'b0, xb} + 5'(xc);
    a4 = xa; b4 = xb; cin4 = xc; start4 = 1'b1;
    tick();                          // accept edge
    start4 = 1'b0; a4 = ~xa; b4 = ~xb;
    check("w4_calc_busy", busy4, 1);
    check("w4_calc_done", done4, 0);
    tick();                          // the single nibble edge
    check("w4_done", done4, 1);
    check("w4_done_busy", busy4, 1);
    check("w4_sum", sum4, t[3:0]);
    check("w4_cout", cout4, t[4]);
    tick();
    check("w4_idle_done", done4, 0);
    check("w4_idle_busy", busy4, 0);
    check("w4_held_sum", sum4, t[3:0]);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_sum4", sum4, 0);
    rst = 1'b0;

    op16(16'h1234, 16'h4321, 1'b0);
    op16(16'hFFFF, 16'h0001, 1'b0);
    op16(16'h000F, 16'h0000, 1'b1);
    op16(16'h7FFF, 16'h8000, 1'b1);

    // Back-to-back: start held high; a = 1 only on the expected accept edges, 0xAAAA otherwise.
    start = 1'b1; b = 16'h0002; cin = 1'b0;
    for (int i = 0; i < 24; i++) begin
      a = (i % 6 == 0) ? 16'h0001 : 16'hAAAA;
      tick();
    end
    start = 1'b0;
    repeat (N + 2) tick();

    // Reset on the second CALC edge aborts the operation.
    a = 16'h1111; b = 16'h1111; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    repeat (N + 2) tick();
    op16(16'h1111, 16'h1111, 1'b0);

    // Random traffic: sparse starts, operands changing every cycle, rare resets.
    for (int i = 0; i < 200; i++) begin
      start = ($urandom_range(0, 2) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      rst   = ($urandom_range(0, 60) == 0);
      tick();
    end
    start = 1'b0; rst = 1'b0;
    repeat (N + 3) tick();

    // 4-bit instance: directed case, boundary cases, then random ones.
    op4(4'h9, 4'h8, 1'b1);
    op4(4'hF, 4'h0, 1'b1);
    op4(4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 12; i++) op4(4'($urandom), 4'($urandom), 1'($urandom));

    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder built around the team's 4-bit ripple-carry adder, RCA_4bit (ports a, b, cin, sum, cout).
- Feeds RCA_4bit one operand nibble per clock, starting from the LSB nibble. It registers the carry-out between nibbles and assembles the result.
- Sits between an operand source using a start/busy handshake and a result consumer that samples on the done pulse.
- Trades latency for area: one RCA_4bit instance serves any WIDTH.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, number of nibble steps. Derived value; not to be overridden.

Ports:
- clk  input  1  Single clock. All state changes on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- start  input  1  Request a new addition. Accepted only in IDLE.
- a  input  WIDTH  Operand A. Sampled on the accept edge.
- b  input  WIDTH  Operand B. Sampled on the accept edge.
- cin  input  1  Carry-in into nibble 0. Sampled on the accept edge.
- busy  output  1  High in CALC and DONE.
- done  output  1  One-cycle pulse: sum/cout valid.
- sum  output  WIDTH  Result. Held until the next completion.
- cout  output  1  Carry-out of the MSB nibble. Held like sum.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, idx=0, carry reg=0, operand/shift regs=0, sum=0, cout=0, busy=0, done=0. rst has priority over all other inputs.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge k: latch a, b, cin into internal registers; idx<=0; carry<=cin; state<=CALC.
  - start=0: remain in IDLE.
- CALC:
  - Each edge: RCA_4bit sees a_reg[4*idx+3:4*idx], b_reg[same], cin=carry.
  - Its sum nibble is written to result-shift reg position idx; carry<=RCA cout; idx<=idx+1.
  - On the edge processing idx=NIBBLES-1: sum<=full assembled result; cout<=RCA cout; state<=DONE.
- DONE: done=1 for exactly this one cycle. The next edge returns to IDLE.
- Latency: accept at edge k; nibbles processed at edges k+1..k+NIBBLES; done high in the cycle following edge k+NIBBLES.
  - Throughput: one operation per NIBBLES+2 cycles.
- busy=1 from the cycle after accept through the DONE cycle inclusive. It is registered, not combinational.
- start while busy=1, including the DONE cycle, is ignored. It is not queued.
- a/b/cin changes after accept have no effect on the operation in flight.
- sum/cout change only on the transition into DONE. They hold the previous result throughout CALC.
- Arithmetic: result = (a + b + cin) mod 2^WIDTH; cout is bit WIDTH of the true sum.
  - A carry must propagate across every nibble boundary (e.g. all-ones + 1).
- WIDTH=4: exactly one CALC cycle.
- Reset mid-CALC or in DONE: immediate return to IDLE with reset values. No done pulse is issued for the aborted operation.

Optional Feature:
- Macro NIBBLE_SERIAL_ADDER_SUB_EN.
- When defined, two ports are added:
  - sub (input, 1): sampled with the operands on the accept edge.
  - ovf (output, 1): reset 0, updated with sum, held.
- sub=1 computes a - b:
  - b is inverted when latched; the carry reg is forced to 1 at accept (cin ignored).
  - cout=1 means no borrow.
  - ovf = signed two's-complement overflow of the WIDTH-bit operation (for add or sub).
- sub=0: normal add; ovf is still computed.
- When not defined: ports sub and ovf do not exist; add-only behaviour exactly as above.

Test Plan:
- WIDTH=16; a=0x1234, b=0x4321, cin=0, start at edge k -> done=1 only in the cycle after edge k+4; sum=0x5555, cout=0; busy high for 5 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Then a=0x000F, b=0x0000, cin=1 -> sum=0x0010, cout=0.
- Back-to-back: start held high continuously with a=0x0001, b=0x0002 -> exactly one done per 6 cycles, sum=0x0003. An operand change to a=0xAAAA mid-CALC does not alter the result.
- Start 0x1111+0x1111, assert rst for one cycle at the 2nd CALC edge -> no done pulse; sum=0, cout=0, busy=0 after reset; a fresh start completes normally.
- SUB_EN defined, sub=1: 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0. Then 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- WIDTH=4: a=0x9, b=0x8, cin=1 -> sum=0x2, cout=1; done in the cycle after edge k+1.
